// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared state encoding and constants for the instruction fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] c_nop_word   = 32'h0000_0000;
  localparam logic [1:0]  c_align_mask = 2'b11;

  function automatic logic is_aligned(input logic [1:0] i_lsb);
    return (i_lsb & c_align_mask) == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_counter.sv
// ============================================================================
// fetch_counter : free-running enable counter with synchronous reset
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch : PC-to-imem request/ack bridge with valid/ready output to decode
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(c_nop_word)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_fault,
  input  logic              instr_ready,
  output logic [31:0]       fetch_count
);

  fetch_state_t      r_state, w_state_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_instr, w_instr_nxt;
  logic              r_instr_valid, w_instr_valid_nxt;
  logic              r_instr_fault, w_instr_fault_nxt;
  logic              w_issue;
  logic              w_consume;
  logic              w_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_instr_fault <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr_fault <= w_instr_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_fault_nxt = r_instr_fault;
    w_issue           = 1'b0;
    w_consume         = 1'b0;
    w_stall           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (flush) begin
          w_instr_valid_nxt = 1'b0;
          w_instr_fault_nxt = 1'b0;
        end else begin
          w_issue = pc_valid;
        end
      end

      S_WAIT: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_instr_nxt       = mem_rdata;
            w_instr_fault_nxt = 1'b0;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_HOLD;
          end
        end else if (flush) begin
          // The outstanding transaction must still complete before re-issuing.
          w_state_nxt = S_DRAIN;
        end
      end

      S_HOLD: begin
        w_stall = !instr_ready;
        if (flush) begin
          w_instr_valid_nxt = 1'b0;
          w_instr_fault_nxt = 1'b0;
          w_state_nxt       = S_IDLE;
        end else if (instr_ready) begin
          w_consume         = r_instr_valid;
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_IDLE;
          w_issue           = pc_valid;
        end
      end

      S_DRAIN: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Shared by IDLE and the back-to-back path out of HOLD.
    if (w_issue) begin
      if (is_aligned(pc[1:0])) begin
        w_mem_addr_nxt = pc;
        w_mem_req_nxt  = 1'b1;
        w_state_nxt    = S_WAIT;
      end else begin
        w_instr_nxt       = NOP_WORD;
        w_instr_fault_nxt = 1'b1;
        w_instr_valid_nxt = 1'b1;
        w_state_nxt       = S_HOLD;
      end
    end
  end

  fetch_counter #(
    .WIDTH (32)
  ) u_counter (
    .clk     (clock),
    .rst     (reset),
    .i_en    (w_consume),
    .o_count (fetch_count)
  );

  assign stall       = w_stall;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign instr_fault = r_instr_fault;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_fault;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  instr_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_fault (instr_fault),
    .instr_ready (instr_ready),
    .fetch_count (fetch_count)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
    total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%0h exp=0", instr_fault); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", fetch_count); end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
  endtask

  task automatic test_aligned();
    @(negedge clock);
    pc = 32'h0000_0004; pc_valid = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL al_idle_stall got=%0h exp=0", stall); end
    @(negedge clock);
    pc_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL al_req got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL al_addr got=%h exp=4", mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL al_valid_early got=%0h exp=0", instr_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL al_wait_stall got=%0h exp=1", stall); end
    @(negedge clock);
    mem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL al_valid got=%0h exp=1", instr_valid); end
    total++; if (instr !== 32'h2008_0005) begin bad++; $display("FAIL al_instr got=%h exp=20080005", instr); end
    total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL al_fault got=%0h exp=0", instr_fault); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL al_req_drop got=%0h exp=0", mem_req); end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL al_consumed got=%0h exp=0", instr_valid); end
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL al_count got=%0d exp=1", fetch_count); end
  endtask

  task automatic test_delayed_ack();
    @(negedge clock);
    pc = 32'h0000_0010; pc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      pc_valid = 1'b0;
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h1111_2222; end
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL dl_req[%0d] got=%0h exp=1", i, mem_req); end
      total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL dl_addr[%0d] got=%h exp=10", i, mem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL dl_valid[%0d] got=%0h exp=0", i, instr_valid); end
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL dl_stall[%0d] got=%0h exp=1", i, stall); end
    end
    @(negedge clock);
    mem_ack = 1'b0;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL dl_valid got=%0h exp=1", instr_valid); end
    total++; if (instr !== 32'h1111_2222) begin bad++; $display("FAIL dl_instr got=%h exp=11112222", instr); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL dl_req_drop got=%0h exp=0", mem_req); end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL dl_count got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_misaligned();
    @(negedge clock);
    pc = 32'h0000_0006; pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0h exp=0", mem_req); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL mis_valid got=%0h exp=1", instr_valid); end
    total++; if (instr_fault !== 1'b1) begin bad++; $display("FAIL mis_fault got=%0h exp=1", instr_fault); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mis_instr got=%h exp=0", instr); end
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_stall got=%0h exp=1", stall); end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mis_consumed got=%0h exp=0", instr_valid); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL mis_count got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_flush_wait();
    @(negedge clock);
    pc = 32'h0000_0020; pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0; flush = 1'b1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fw_req got=%0h exp=1", mem_req); end
    total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL fw_addr got=%h exp=20", mem_addr); end
    @(negedge clock);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fw_drain_req got=%0h exp=1", mem_req); end
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fw_drain_stall got=%0h exp=1", stall); end
    @(negedge clock);
    flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fw_req_hold got=%0h exp=1", mem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fw_valid got=%0h exp=0", instr_valid); end
    @(negedge clock);
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fw_req_drop got=%0h exp=0", mem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fw_no_data got=%0h exp=0", instr_valid); end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fw_idle_stall got=%0h exp=0", stall); end
    pc = 32'h0000_0008; pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    total++; if (mem_addr !== 32'h8 || mem_req !== 1'b1) begin bad++; $display("FAIL fw_refetch got=%h/%0h exp=8/1", mem_addr, mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clock);
    mem_ack = 1'b0;
    total++; if (instr !== 32'h13 || instr_valid !== 1'b1) begin bad++; $display("FAIL fw_refetch_instr got=%h/%0h exp=13/1", instr, instr_valid); end
    total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL fw_fault_clr got=%0h exp=0", instr_fault); end
  endtask

  task automatic test_hold_stall();
    instr_ready = 1'b0; pc = 32'h0000_0040; pc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL hs_stall[%0d] got=%0h exp=1", i, stall); end
      @(negedge clock);
      total++; if (instr !== 32'h13 || instr_valid !== 1'b1) begin bad++; $display("FAIL hs_hold[%0d] got=%h/%0h exp=13/1", i, instr, instr_valid); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hs_req[%0d] got=%0h exp=0", i, mem_req); end
    end
    instr_ready = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hs_release got=%0h exp=0", stall); end
    @(negedge clock);
    instr_ready = 1'b0; pc_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL hs_issue got=%0h/%h exp=1/40", mem_req, mem_addr); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL hs_count got=%0d exp=4", fetch_count); end
    mem_ack = 1'b1; mem_rdata = 32'h0040_0093;
    @(negedge clock);
    mem_ack = 1'b0;
    total++; if (instr !== 32'h0040_0093) begin bad++; $display("FAIL hs_instr got=%h exp=00400093", instr); end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL hs_count2 got=%0d exp=5", fetch_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    instr_ready = 1'b1; mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 32'h0000_0100 + 32'(4 * k);
      pc = a; pc_valid = 1'b1; mem_rdata = 32'hA000_0000 | a;
      @(negedge clock);
      pc_valid = 1'b0;
      total++; if (mem_req !== 1'b1 || mem_addr !== a) begin bad++; $display("FAIL b2b_req[%0d] got=%0h/%h exp=1/%h", k, mem_req, mem_addr, a); end
      @(negedge clock);
      total++; if (instr_valid !== 1'b1 || instr !== (32'hA000_0000 | a)) begin bad++; $display("FAIL b2b_instr[%0d] got=%0h/%h exp=1/%h", k, instr_valid, instr, 32'hA000_0000 | a); end
      total++; if (fetch_count !== 32'(5 + k)) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", k, fetch_count, 5 + k); end
    end
    mem_ack = 1'b0;
    @(negedge clock);
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || fetch_count !== 32'd9) begin bad++; $display("FAIL b2b_end got=%0h/%0d exp=0/9", instr_valid, fetch_count); end
  endtask

  task automatic test_reset_wait();
    pc = 32'h0000_0080; pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rw_req got=%0h exp=1", mem_req); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rw_mem got=%0h/%h exp=0/0", mem_req, mem_addr); end
    total++; if (instr !== 32'h0 || instr_valid !== 1'b0 || instr_fault !== 1'b0) begin bad++; $display("FAIL rw_instr got=%h/%0h/%0h exp=0/0/0", instr, instr_valid, instr_fault); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rw_count got=%0d exp=0", fetch_count); end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rw_stall got=%0h exp=0", stall); end
  endtask

  task automatic test_flush_hold();
    pc = 32'h0000_0041; pc_valid = 1'b1;
    @(negedge clock);
    total++; if (instr_valid !== 1'b1 || instr_fault !== 1'b1) begin bad++; $display("FAIL fh_pre got=%0h/%0h exp=1/1", instr_valid, instr_fault); end
    flush = 1'b1; instr_ready = 1'b1; pc = 32'h0000_0200; pc_valid = 1'b1;
    @(negedge clock);
    flush = 1'b0; instr_ready = 1'b0; pc_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || instr_fault !== 1'b0) begin bad++; $display("FAIL fh_clear got=%0h/%0h exp=0/0", instr_valid, instr_fault); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL fh_count got=%0d exp=0", fetch_count); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fh_req got=%0h exp=0", mem_req); end
  endtask

  task automatic test_wrap();
    force dut.u_counter.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.u_counter.r_count;
    pc = 32'h0000_0003; pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    total++; if (fetch_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wr_pre got=%h exp=ffffffff", fetch_count); end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL wr_valid got=%0h exp=1", instr_valid); end
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL wr_wrap got=%h exp=0", fetch_count); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_delayed_ack();
    test_misaligned();
    test_flush_wait();
    test_hold_stall();
    test_back_to_back();
    test_reset_wait();
    test_flush_hold();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting between the program counter register and instruction memory. It accepts a word address from the PC side, issues a request/acknowledge transaction to instruction memory, and presents the returned instruction to the decode stage through a valid/ready handshake. It also supports redirect flushes, misaligned-address faults and a completed-fetch counter. It is the consuming end of the PC's `pc` output, so that memory latency can be hidden behind a stall instead of an asynchronous read.

## Interface
- `ADDR_W`, default 32: width of PC and memory address.
- `DATA_W`, default 32: instruction width.
- `NOP_WORD`, default 32'h0000_0000: value driven on `instr` when a fault is returned.

Ports:
- `clock`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-high; sampled on rising edge of `clock`.
- `pc`  in  ADDR_W: fetch address from the PC register.
- `pc_valid`  in  1: request to fetch `pc`.
- `flush`  in  1: redirect; discards any in-flight or held instruction.
- `stall`  out  1: high whenever a new `pc_valid` cannot be accepted this cycle.
- `mem_req`  out  1: memory request, held until acknowledged.
- `mem_addr`  out  ADDR_W: registered request address.
- `mem_ack`  in  1: one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_W: returned instruction word.
- `instr`  out  DATA_W: registered instruction to decode.
- `instr_valid`  out  1: `instr` is valid.
- `instr_fault`  out  1: the held instruction comes from a misaligned PC.
- `instr_ready`  in  1: decode consumes `instr` when `instr_valid && instr_ready`.
- `fetch_count`  out  32: number of instructions consumed, wraps modulo 2^32.

## Operation
- FSM states: IDLE, WAIT, HOLD, DRAIN.
- **Reset:** state=IDLE. `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_valid`=0, `instr_fault`=0, `fetch_count`=0.
- **IDLE:** `stall`=0.
  - `pc_valid` with `pc[1:0]==0`: latch `mem_addr`=`pc`, set `mem_req`=1, go to WAIT.
  - `pc_valid` with `pc[1:0]!=0`: load `instr`=NOP_WORD, set `instr_fault`=1 and `instr_valid`=1, go to HOLD. No memory request is issued.
- **WAIT:** `stall`=1; `mem_req` and `mem_addr` are held stable.
  - `mem_ack`: capture `instr`=`mem_rdata`, `instr_fault`=0, `instr_valid`=1, `mem_req`=0; go to HOLD.
- **HOLD:** `stall`=!`instr_ready`.
  - Handshake (`instr_valid && instr_ready`): increment `fetch_count`, clear `instr_valid`.
  - If `pc_valid` arrives in the same cycle, process it exactly as in IDLE (back-to-back issue). Otherwise go to IDLE.
- **flush:** has priority over every other event in the same cycle.
  - IDLE/HOLD: clear `instr_valid` and `instr_fault`; go to IDLE. A consume in the same cycle is not counted. `pc_valid` in the same cycle is ignored.
  - WAIT without `mem_ack`: go to DRAIN. `mem_req` stays high until ack, because the transaction must complete.
  - WAIT with `mem_ack`: drop the data, set `mem_req`=0, go to IDLE.
- **DRAIN:** `stall`=1.
  - On `mem_ack`: discard `mem_rdata`, set `mem_req`=0, go to IDLE.
  - Further flushes have no effect.
- `instr` is stable whenever `instr_valid`=1 and not consumed.
- Reset mid-transaction returns all outputs to reset values on the next edge. The memory must tolerate a dropped `mem_req`.

## Timing
- Registered outputs: `mem_req`, `mem_addr`, `instr`, `instr_valid`, `instr_fault`, `fetch_count`. Combinational: `stall` only.
- Minimum latency, aligned fetch: `pc_valid` in cycle 0 → `mem_req` in cycle 1 → `mem_ack` in cycle 1 → `instr_valid` in cycle 2.
- Each extra cycle of `mem_ack` delay adds one cycle.
- Misaligned fetch: `pc_valid` in cycle 0 → `instr_valid` with `instr_fault` in cycle 1.
- Back-to-back with zero-wait memory and `instr_ready` tied high: one instruction every 2 cycles.
- `mem_ack` is ignored in IDLE and HOLD. `mem_ack` with `mem_req`=0 is a protocol error, and the block takes no action on it.

## Structure
- Shared package `fetch_pkg`: FSM state encoding (IDLE=0, WAIT=1, HOLD=2, DRAIN=3), `NOP_WORD`, and the alignment mask constant 2'b11.
- One sub-module, `fetch_counter`: 32-bit enable counter with synchronous reset, used for `fetch_count`.
- All other logic sits in `instr_fetch`.

## Test plan
- Reset, then `pc`=0x0000_0004 with `pc_valid`, `mem_ack` same cycle with `mem_rdata`=0x2008_0005 → `instr_valid` in cycle 2, `instr`=0x2008_0005; `fetch_count`=1 after consume.
- `mem_ack` delayed 3 cycles after `mem_req` → `mem_addr` stable for all 4 cycles, `stall`=1 throughout, `instr_valid` the cycle after ack.
- `pc`=0x0000_0006 → no `mem_req`; next cycle `instr_valid`=1, `instr_fault`=1, `instr`=0x0.
- `flush` in WAIT, ack 2 cycles later with 0xDEAD_BEEF → `instr_valid` stays 0; `mem_req` drops after ack; next `pc`=0x8 fetches normally.
- `instr_ready`=0 for 4 cycles in HOLD while `pc_valid`=1 → `stall`=1, `instr` unchanged, no `mem_req`. Raising `instr_ready` issues the next fetch in the same cycle.
- `fetch_count` preloaded via 0xFFFF_FFFF consumes (or forced) → next consume wraps it to 0. Reset asserted during WAIT → all outputs return to 0.
